// File: rtl/axis_frame_skid.sv
`default_nettype none
// ============================================================================
// axis_frame_skid : tlast-inserting AXI-Stream front end with 2-entry skid
// Revision 1.0
// ============================================================================
module axis_frame_skid #(
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 16,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   output logic                  m_tlast,
   input  logic                  m_tready,
   input  logic [LEN_WIDTH-1:0]  frame_len,
   input  logic                  flush,
   output logic [CNT_WIDTH-1:0]  frames_done
);

   logic                  s_acc;
   logic                  m_acc;
   logic [LEN_WIDTH-1:0]  beat_cnt;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  eff_len;
   logic [LEN_WIDTH:0]    beat_next;
   logic                  flush_pend;
   logic                  in_last;
   logic [DATA_WIDTH-1:0] skid_data;
   logic                  skid_last;
   logic                  skid_valid;

   assign s_acc = s_tvalid & s_tready;
   assign m_acc = m_tvalid & m_tready;

   // The first beat of a frame uses the live frame_len; later beats use the latched copy.
   assign eff_len   = (beat_cnt == '0) ? frame_len : len_q;
   assign beat_next = {1'b0, beat_cnt} + (LEN_WIDTH + 1)'(1);
   assign in_last   = (beat_next >= {1'b0, eff_len}) | flush_pend | flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt   <= '0;
         len_q      <= '0;
         flush_pend <= 1'b0;
      end else if (s_acc) begin
         if (beat_cnt == '0) begin
            len_q <= frame_len;
         end
         if (in_last) begin
            beat_cnt   <= '0;
            flush_pend <= 1'b0;
         end else begin
            beat_cnt <= beat_next[LEN_WIDTH-1:0];
         end
      end else if (flush) begin
         flush_pend <= 1'b1;
      end
   end

   // Skid state is implied by {m_tvalid, skid_valid}: EMPTY, BUSY, FULL.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_tvalid   <= 1'b0;
         m_tdata    <= '0;
         m_tlast    <= 1'b0;
         s_tready   <= 1'b1;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_last  <= 1'b0;
      end else if (!m_tvalid) begin
         if (s_acc) begin
            m_tdata  <= s_tdata;
            m_tlast  <= in_last;
            m_tvalid <= 1'b1;
         end
      end else if (!skid_valid) begin
         if (s_acc && m_acc) begin
            m_tdata <= s_tdata;
            m_tlast <= in_last;
         end else if (s_acc) begin
            skid_data  <= s_tdata;
            skid_last  <= in_last;
            skid_valid <= 1'b1;
            s_tready   <= 1'b0;
         end else if (m_acc) begin
            m_tvalid <= 1'b0;
         end
      end else if (m_acc) begin
         m_tdata    <= skid_data;
         m_tlast    <= skid_last;
         skid_valid <= 1'b0;
         s_tready   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frames_done <= '0;
      end else if (m_acc && m_tlast) begin
         frames_done <= frames_done + CNT_WIDTH'(1);
      end
   end

endmodule
`default_nettype wire
